alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, registered successor to the 12-bit combinational CPU ALU.
- Adds valid/ready handshakes on the operand and result sides, condition flags, and an iterative multi-cycle multiply on opcode 7.
- Sits between the decode stage and writeback; the width is generalised by parameter.

Parameters:
- WIDTH, 12, operand/result width in bits (>=4).
- MUL_EN, 1, 1 = opcode 7 is the iterative multiply; 0 = opcode 7 returns 0 with single-cycle latency.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block can accept a bundle
- opcode  input  3  operation select
- op1  input  WIDTH  operand 1
- op2  input  WIDTH  operand 2
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- flags  output  4  {N,Z,C,V}, registered alongside result

Behaviour:
- Clocking and reset:
  - Single clock.
  - rst asynchronous, active-high. On assertion: state=IDLE, out_valid=0, result=0, flags=0, multiply datapath cleared. in_ready=1 after reset.
- Transfers:
  - Input transfer = in_valid & in_ready at a rising edge.
  - Output transfer = out_valid & out_ready at a rising edge.
- FSM states: IDLE, MUL, DONE.
  - IDLE: on input transfer, ops 0-6 (or op 7 with MUL_EN=0) -> DONE; result and flags registered that edge. Op 7 with MUL_EN=1 -> MUL; op1, op2 latched, accumulator cleared, counter=0.
  - MUL: one shift-add step per cycle; after WIDTH steps -> DONE.
  - DONE: out_valid=1; result and flags stable while out_ready=0.
    - Output transfer without new input -> IDLE.
    - Output transfer plus new input transfer in the same cycle -> start the new operation (DONE or MUL) with no bubble.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is 0 in MUL. Operands change freely when not accepted.
- Latency, input transfer at edge N:
  - Single-cycle ops: out_valid high from edge N.
  - MUL: out_valid high from edge N+WIDTH+1.
- Opcodes and arithmetic (modulo 2^WIDTH):
  - 0 ADD: C = carry out; V = signed overflow.
  - 1 SUB (op1-op2): C=1 iff op1>=op2 unsigned (no borrow); V = signed overflow.
  - 2 AND, 3 OR, 4 XOR: C=0, V=0.
  - 5 SHL logical by op2 unsigned: if op2>=WIDTH, result=0. C=0, V=0.
  - 6 SHR logical, same rules as SHL.
  - 7 MUL: unsigned, low WIDTH bits of the 2*WIDTH product. C=1 iff any upper WIDTH bit is nonzero; V=0.
- Flags: N = result[WIDTH-1]; Z = (result==0); both computed from the final result for every opcode.
- in_valid while in_ready=0 is ignored; there is no queueing, and the upstream stage must hold.
- rst mid-MUL: operation discarded, no out_valid pulse, block returns to IDLE.
- out_ready held high with no traffic: out_valid stays 0, no spurious transfer.

Test Plan:
- WIDTH=12, ADD 0xFFF+0x001 -> result 0x000, flags N0 Z1 C1 V0, out_valid one edge after accept.
- SUB 0x800-0x001 -> 0x7FF, N0 Z0 C1 V1. SUB 0x003-0x005 -> 0xFFE, N1 C0 V0.
- MUL 0x040*0x040 -> 0x000, Z1 C1; out_valid exactly 13 edges after accept; in_ready=0 throughout MUL. MUL 0x00F*0x011 -> 0x0FF, C0.
- Backpressure: ADD 0x123+0x111 with out_ready=0 for 5 cycles -> result 0x234 held stable, in_ready=0; out_ready=1 with in_valid=1 (AND 0xF0F&0x0FF) -> back-to-back accept, next result 0x00F.
- SHL 0x001 by op2=11 -> 0x800, N1. SHL by op2=12 -> 0x000, Z1. SHR 0x800 by 11 -> 0x001.
- Assert rst 4 cycles into a MUL -> out_valid=0, result=0, flags=0, in_ready=1 immediately. A subsequent XOR 0xAAA^0x555 -> 0xFFF, N1.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes on both sides, NZCV flags,
// and an iterative shift-add multiply on opcode 7.
module alu_pipe #(
    parameter int WIDTH  = 12,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int                CW          = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]     LAST_STEP   = CW'(WIDTH);
    localparam logic [WIDTH-1:0]  SHIFT_LIMIT = WIDTH'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic               w_accept;
    logic               w_start_mul;
    logic               w_mul_done;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_c;
    logic               w_alu_v;

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] res,
                                              input logic c,
                                              input logic v);
        return {res[WIDTH-1], (res == '0), c, v};
    endfunction

    assign w_accept    = in_valid & in_ready;
    assign w_start_mul = (MUL_EN != 0) && (opcode == 3'd7);
    assign w_mul_done  = (r_cnt == LAST_STEP);

    assign w_sum  = {1'b0, op1} + {1'b0, op2};
    assign w_diff = {1'b0, op1} - {1'b0, op2};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A DONE state can hand off its result and take a new bundle in the same cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_start_mul ? MUL : DONE;
                end
            end
            MUL: begin
                if (w_mul_done) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (w_accept) begin
                    w_next_state = w_start_mul ? MUL : DONE;
                end else if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
        out_valid = (r_state == DONE);
        result    = r_result;
        flags     = r_flags;
    end

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (opcode)
            3'd0: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
                w_alu_v   = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != op1[WIDTH-1]);
            end
            3'd1: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_alu_c   = ~w_diff[WIDTH];
                w_alu_v   = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != op1[WIDTH-1]);
            end
            3'd2: w_alu_res = op1 & op2;
            3'd3: w_alu_res = op1 | op2;
            3'd4: w_alu_res = op1 ^ op2;
            3'd5: w_alu_res = (op2 >= SHIFT_LIMIT) ? '0 : (op1 << op2);
            3'd6: w_alu_res = (op2 >= SHIFT_LIMIT) ? '0 : (op1 >> op2);
            default: w_alu_res = '0;
        endcase
    end

    // Multiply runs WIDTH shift-add steps, then spends one more cycle registering the product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_accept) begin
            if (w_start_mul) begin
                r_mcand  <= {{WIDTH{1'b0}}, op1};
                r_mplier <= op2;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else begin
                r_result <= w_alu_res;
                r_flags  <= make_flags(w_alu_res, w_alu_c, w_alu_v);
            end
        end else if (r_state == MUL) begin
            if (w_mul_done) begin
                r_result <= r_acc[WIDTH-1:0];
                r_flags  <= make_flags(r_acc[WIDTH-1:0], |r_acc[2*WIDTH-1:WIDTH], 1'b0);
            end else begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
            end
        end
    end

endmodule
